// File: rtl/drum_mac_accum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | drum_mac_accum: LANES-wide DRUM/exact multiply, adder tree, packet accum  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module drum_mac_accum #(
  parameter int LANES  = 8,
  parameter int DW     = 16,
  parameter int K      = 6,
  parameter int ACC_W  = 40,
  parameter int BEAT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic                  in_exact,
  input  logic [LANES*DW-1:0]   in_ifm,
  input  logic [LANES*DW-1:0]   in_weight,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      out_ofm,
  output logic                  out_sat,
  output logic [BEAT_W-1:0]     out_beats
);

  localparam int SUM_W = 2*DW + $clog2(LANES);
  localparam int SHW   = $clog2(2*DW);
  localparam int XW    = (ACC_W + 1 > SUM_W + 1) ? ACC_W + 1 : SUM_W + 1;

  // Returns {shift, truncated operand}; operands below 2^K pass through untouched.
  function automatic logic [SHW+DW-1:0] drum_trunc(input logic [DW-1:0] x);
    int              p;
    logic [DW-1:0]   t;
    logic [SHW-1:0]  s;
    p = -1;
    for (int i = 0; i < DW; i++) begin
      if (x[i]) p = i;
    end
    t = x;
    s = '0;
    if (p >= K) begin
      s    = SHW'(p - K + 1);
      t    = x >> s;
      t[0] = 1'b1;
    end
    return {s, t};
  endfunction

  function automatic logic [2*DW-1:0] drum_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [SHW+DW-1:0] ra;
    logic [SHW+DW-1:0] rb;
    logic [2*DW-1:0]   m;
    ra = drum_trunc(a);
    rb = drum_trunc(b);
    m  = (2*DW)'(ra[DW-1:0]) * (2*DW)'(rb[DW-1:0]);
    return m << (ra[SHW+DW-1:DW] + rb[SHW+DW-1:DW]);
  endfunction

  logic stall;
  logic accept;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  // S0: input capture
  logic                s0_valid, s0_last, s0_exact;
  logic [LANES*DW-1:0] s0_ifm, s0_weight;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid  <= 1'b0;
      s0_last   <= 1'b0;
      s0_exact  <= 1'b0;
      s0_ifm    <= '0;
      s0_weight <= '0;
    end else if (!stall) begin
      s0_valid <= accept;
      if (accept) begin
        s0_last   <= in_last;
        s0_exact  <= in_exact;
        s0_ifm    <= in_ifm;
        s0_weight <= in_weight;
      end
    end
  end

  // S1: per-lane products
  logic [2*DW-1:0] prod_c [LANES];
  logic [2*DW-1:0] s1_prod [LANES];
  logic            s1_valid, s1_last;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    always_comb begin
      if (s0_exact)
        prod_c[g] = (2*DW)'(s0_ifm[g*DW +: DW]) * (2*DW)'(s0_weight[g*DW +: DW]);
      else
        prod_c[g] = drum_mul(s0_ifm[g*DW +: DW], s0_weight[g*DW +: DW]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      for (int i = 0; i < LANES; i++) s1_prod[i] <= '0;
    end else if (!stall) begin
      s1_valid <= s0_valid;
      s1_last  <= s0_last;
      for (int i = 0; i < LANES; i++) s1_prod[i] <= prod_c[i];
    end
  end

  // S2: lane sum
  logic [SUM_W-1:0] sum_c, s2_sum;
  logic             s2_valid, s2_last;

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < LANES; i++) sum_c = sum_c + SUM_W'(s1_prod[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_sum   <= '0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_sum   <= sum_c;
    end
  end

  // S3: accumulate with sticky saturation, emit result on last beat
  logic [ACC_W-1:0]  acc, acc_next;
  logic              sat, sat_next;
  logic [BEAT_W-1:0] count, count_next;
  logic [XW-1:0]     acc_wide;

  always_comb begin
    acc_wide   = XW'(acc) + XW'(s2_sum);
    acc_next   = acc_wide[ACC_W-1:0];
    sat_next   = sat;
    if (sat || (|acc_wide[XW-1:ACC_W])) begin
      acc_next = '1;
      sat_next = 1'b1;
    end
    count_next = (&count) ? count : count + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      sat       <= 1'b0;
      count     <= '0;
      out_valid <= 1'b0;
      out_ofm   <= '0;
      out_sat   <= 1'b0;
      out_beats <= '0;
    end else if (!stall) begin
      out_valid <= s2_valid & s2_last;
      if (s2_valid) begin
        if (s2_last) begin
          out_ofm   <= acc_next;
          out_sat   <= sat_next;
          out_beats <= count_next;
          acc       <= '0;
          sat       <= 1'b0;
          count     <= '0;
        end else begin
          acc   <= acc_next;
          sat   <= sat_next;
          count <= count_next;
        end
      end
    end
  end

endmodule
`default_nettype wire
